// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared FSM states and register offsets for the PWM fade sequencer.
package pwm_fade_pkg;
   typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;
   localparam logic [4:0] CTRL_OFF  = 5'h10;
   localparam logic [4:0] START_OFF = 5'h14;
   localparam logic [4:0] END_OFF   = 5'h18;
   localparam logic [4:0] CFG_OFF   = 5'h1C;
   localparam logic [3:0] DUTY_OFF  = 4'h8;
endpackage

// File: rtl/pwm_fade_step.sv
// pwm_fade_step: one saturating duty step toward target; never overshoots or wraps.
module pwm_fade_step (
   input  logic [31:0] cur,
   input  logic [31:0] step,
   input  logic [31:0] target,
   input  logic        dir_up,
   output logic [31:0] nxt
);
   logic [32:0] sum;
   logic [32:0] diff;
   always_comb begin
      sum  = {1'b0, cur} + {1'b0, step};
      diff = {1'b0, cur} - {1'b0, step};
      nxt  = dir_up ? ((sum[32] || sum[31:0] > target) ? target : sum[31:0])
                    : ((diff[32] || diff[31:0] < target) ? target : diff[31:0]);
   end
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: CPU-to-PWM bus bridge that autonomously ramps the PWM duty register.
// Ping-pong looping (CTRL.LOOP) is built only when PWM_FADE_LOOP_EN is defined.
module pwm_fade_ctrl
   import pwm_fade_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_sel,
   input  logic        i_we,
   input  logic [4:0]  i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        m_sel,
   output logic        m_we,
   output logic [3:0]  m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   output logic        o_done
);
   state_t      state;
   logic        go, loop, dir_up, tgt_end;
   logic [31:0] start_r, end_r, cfg_r, cur_duty, target, step, next_duty;
   logic [15:0] cnt, interval;
   logic        pt, sw, busy, wr;
   always_comb begin
      pt       = i_sel && !i_addr[4];
      sw       = i_sel && i_we && i_addr[4];
      busy     = state != IDLE;
      wr       = state == WRITE;
      target   = tgt_end ? end_r : start_r;
      step     = {16'b0, (cfg_r[31:16] == 16'd0) ? 16'd1 : cfg_r[31:16]};
      interval = (cfg_r[15:0] == 16'd0) ? 16'd1 : cfg_r[15:0];
      m_sel    = pt || wr;
      m_we     = pt ? i_we : wr;
      m_addr   = pt ? i_addr[3:0] : wr ? DUTY_OFF : 4'h0;
      m_wdata  = pt ? i_wdata : wr ? cur_duty : 32'h0;
      o_rdata  = pt ? m_rdata :
                 !i_sel ? 32'h0 :
                 (i_addr == CTRL_OFF)  ? {cur_duty[15:0], 13'b0, busy, loop, go} :
                 (i_addr == START_OFF) ? start_r :
                 (i_addr == END_OFF)   ? end_r :
                 (i_addr == CFG_OFF)   ? cfg_r : 32'h0;
   end
   pwm_fade_step u_step (
      .cur    (cur_duty),
      .step   (step),
      .target (target),
      .dir_up (dir_up),
      .nxt    (next_duty)
   );
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         go       <= 1'b0;
         loop     <= 1'b0;
         dir_up   <= 1'b1;
         tgt_end  <= 1'b1;
         start_r  <= 32'h0;
         end_r    <= 32'h0;
         cfg_r    <= 32'h0;
         cur_duty <= 32'h0;
         cnt      <= 16'h0;
         o_done   <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (sw && i_addr == START_OFF) start_r <= i_wdata;
         if (sw && i_addr == END_OFF) end_r <= i_wdata;
         if (sw && i_addr == CFG_OFF) cfg_r <= i_wdata;
         if (sw && i_addr == CTRL_OFF) begin
            go <= i_wdata[0];
`ifdef PWM_FADE_LOOP_EN
            loop <= i_wdata[1];
`endif
            state    <= i_wdata[0] ? WRITE : IDLE;
            cur_duty <= i_wdata[0] ? start_r : cur_duty;
            dir_up   <= i_wdata[0] ? (start_r <= end_r) : dir_up;
            tgt_end  <= 1'b1;
         end else if (state == WRITE && !pt) begin
            // CPU pass-through owns the bus this cycle otherwise; we retry next cycle
            cnt <= 16'h0;
            if (cur_duty == target && !loop) begin
               go     <= 1'b0;
               o_done <= 1'b1;
               state  <= IDLE;
            end else begin
               tgt_end <= (cur_duty == target) ? !tgt_end : tgt_end;
               dir_up  <= (cur_duty == target) ? !dir_up : dir_up;
               state   <= WAIT;
            end
         end else if (state == WAIT) begin
            cnt      <= cnt + 16'd1;
            cur_duty <= (cnt == interval - 16'd1) ? next_duty : cur_duty;
            state    <= (cnt == interval - 16'd1) ? WRITE : WAIT;
         end
      end
   end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: scoreboard bench; expected PWM writes and done pulses are queued with their cycle.
module tb_pwm_fade_ctrl;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        i_sel = 1'b0;
   logic        i_we = 1'b0;
   logic [4:0]  i_addr = 5'h0;
   logic [31:0] i_wdata = 32'h0;
   logic [31:0] m_rdata = 32'hA5A5_0000;
   logic [31:0] o_rdata, m_wdata;
   logic        m_sel, m_we, o_done;
   logic [3:0]  m_addr;
   typedef struct {logic [3:0] a; logic [31:0] d; int c;} wr_t;
   wr_t exp_q[$];
   int  done_q[$];
   wr_t mon_e;
   int  mon_c;
   int  cyc = 0, checks = 0, errors = 0, g = 0;

   pwm_fade_ctrl dut (
      .clk(clk), .resetn(resetn), .i_sel(i_sel), .i_we(i_we), .i_addr(i_addr),
      .i_wdata(i_wdata), .o_rdata(o_rdata), .m_sel(m_sel), .m_we(m_we),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .o_done(o_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic cpu_wr(input logic [4:0] a, input logic [31:0] d);
      i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
      tick();
      i_sel = 1'b0; i_we = 1'b0; i_addr = 5'h0; i_wdata = 32'h0;
   endtask

   task automatic cpu_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
      i_sel = 1'b1; i_we = 1'b0; i_addr = a;
      #1 check(name, o_rdata, exp);
      tick();
      i_sel = 1'b0; i_addr = 5'h0;
   endtask

   task automatic push(input logic [3:0] a, input logic [31:0] d, input int c);
      wr_t e;
      e.a = a; e.d = d; e.c = c;
      exp_q.push_back(e);
   endtask

   task automatic setup(input logic [31:0] s, input logic [31:0] e, input logic [31:0] cfg);
      cpu_wr(5'h14, s);
      cpu_wr(5'h18, e);
      cpu_wr(5'h1C, cfg);
   endtask

   // monitor: every PWM-side write and every done pulse must match the head of its queue
   always @(negedge clk) begin
      if (resetn) begin
         if (m_sel && m_we) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write addr=%h data=%h cyc=%0d", m_addr, m_wdata, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", {28'h0, m_addr}, {28'h0, mon_e.a});
               check("wr_data", m_wdata, mon_e.d);
               check("wr_cycle", cyc, mon_e.c);
            end
         end
         if (o_done) begin
            if (done_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done cyc=%0d", cyc);
            end else begin
               mon_c = done_q.pop_front();
               check("done_cycle", cyc, mon_c);
            end
         end
      end
   end

   initial begin
      tick(); tick();
      #1 check("rst_m_sel", {31'h0, m_sel}, 32'h0);
      check("rst_done", {31'h0, o_done}, 32'h0);
      resetn = 1'b1;
      cpu_rd("rst_ctrl", 5'h10, 32'h0);
      cpu_rd("rst_start", 5'h14, 32'h0);
      cpu_rd("rst_end", 5'h18, 32'h0);
      cpu_rd("rst_cfg", 5'h1C, 32'h0);
      cpu_rd("pt_read", 5'h04, 32'hA5A5_0000);

      // basic up ramp: 0..10 step 3, interval 2
      setup(32'd0, 32'd10, {16'd3, 16'd2});
      g = cyc;
      push(4'h8, 32'd0, g + 1); push(4'h8, 32'd3, g + 4); push(4'h8, 32'd6, g + 7);
      push(4'h8, 32'd9, g + 10); push(4'h8, 32'd10, g + 13); done_q.push_back(g + 14);
      cpu_wr(5'h10, 32'h1);
      wait_until(g + 16);
      cpu_rd("ctrl_after_done", 5'h10, 32'h000A_0000);

      // down ramp with LOOP requested, then abort
      setup(32'd10, 32'd0, {16'd4, 16'd1});
      g = cyc;
      push(4'h8, 32'd10, g + 1); push(4'h8, 32'd6, g + 3);
      push(4'h8, 32'd2, g + 5);  push(4'h8, 32'd0, g + 7);
`ifdef PWM_FADE_LOOP_EN
      push(4'h8, 32'd4, g + 9);  push(4'h8, 32'd8, g + 11);
      push(4'h8, 32'd10, g + 13); push(4'h8, 32'd6, g + 15);
`else
      done_q.push_back(g + 8);
`endif
      cpu_wr(5'h10, 32'h3);
      wait_until(g + 2);
`ifdef PWM_FADE_LOOP_EN
      cpu_rd("ctrl_busy", 5'h10, 32'h000A_0007);
`else
      cpu_rd("ctrl_busy", 5'h10, 32'h000A_0005);
`endif
      wait_until(g + 16);
      cpu_wr(5'h10, 32'h0);
      wait_until(g + 26);

      // saturation at top of range, no wrap
      setup(32'hFFFF_FFF0, 32'hFFFF_FFFF, {16'h0020, 16'd1});
      g = cyc;
      push(4'h8, 32'hFFFF_FFF0, g + 1); push(4'h8, 32'hFFFF_FFFF, g + 3); done_q.push_back(g + 4);
      cpu_wr(5'h10, 32'h1);
      wait_until(g + 8);

      // contention: CPU PERIOD write collides with pending duty write
      setup(32'd0, 32'd2, {16'd1, 16'd3});
      g = cyc;
      push(4'h8, 32'd0, g + 1); push(4'h4, 32'h1234, g + 5);
      push(4'h8, 32'd1, g + 6); push(4'h8, 32'd2, g + 10); done_q.push_back(g + 11);
      cpu_wr(5'h10, 32'h1);
      wait_until(g + 5);
      cpu_wr(5'h04, 32'h1234);
      wait_until(g + 14);

      // STEP=0 and INTERVAL=0 act as 1
      setup(32'd0, 32'd2, 32'h0);
      g = cyc;
      push(4'h8, 32'd0, g + 1); push(4'h8, 32'd1, g + 3); push(4'h8, 32'd2, g + 5); done_q.push_back(g + 6);
      cpu_wr(5'h10, 32'h1);
      wait_until(g + 9);

      // START == END: single write then done
      setup(32'd5, 32'd5, {16'd1, 16'd1});
      g = cyc;
      push(4'h8, 32'd5, g + 1); done_q.push_back(g + 2);
      cpu_wr(5'h10, 32'h1);
      wait_until(g + 6);

      // reset mid-ramp
      setup(32'd0, 32'd100, {16'd1, 16'd2});
      g = cyc;
      push(4'h8, 32'd0, g + 1); push(4'h8, 32'd1, g + 4);
      cpu_wr(5'h10, 32'h1);
      wait_until(g + 5);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("rstmid_m_sel", {31'h0, m_sel}, 32'h0);
      check("rstmid_done", {31'h0, o_done}, 32'h0);
      cpu_rd("rstmid_ctrl", 5'h10, 32'h0);
      cpu_rd("rstmid_start", 5'h14, 32'h0);
      cpu_rd("rstmid_end", 5'h18, 32'h0);
      cpu_rd("rstmid_cfg", 5'h1C, 32'h0);
      wait_until(g + 30);

      check("exp_writes_left", exp_q.size(), 32'h0);
      check("exp_done_left", done_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
